// File: rtl/spi_reg_bank_peripheral_if.sv
// rtl/spi_reg_bank_peripheral_if.sv - SPI pin bundle between an external controller and the peripheral
interface spi_reg_bank_peripheral_if;
    logic sclk;
    logic copi;
    logic ncs;
    logic cipo;
    logic cipo_oe;

    modport master (
        output sclk,
        output copi,
        output ncs,
        input  cipo,
        input  cipo_oe
    );

    modport slave (
        input  sclk,
        input  copi,
        input  ncs,
        output cipo,
        output cipo_oe
    );
endinterface

// File: rtl/spi_reg_bank_peripheral.sv
// rtl/spi_reg_bank_peripheral.sv - SPI mode-0 peripheral with register bank, readback and frame error counter
module spi_reg_bank_peripheral #(
    parameter int NUM_REGS    = 5,
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 7,
    parameter int SYNC_STAGES = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    spi_reg_bank_peripheral_if.slave   spi,
    output logic [NUM_REGS*DATA_W-1:0] regs_flat,
    output logic                       wr_pulse,
    output logic [ADDR_W-1:0]          wr_addr,
    output logic [7:0]                 err_count
);
    localparam int CMD_BITS = 1 + ADDR_W;
    localparam int FRAME    = CMD_BITS + DATA_W;
    localparam int CNT_W    = $clog2(FRAME + 2);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CMD,
        S_DATA,
        S_DISCARD
    } state_t;

    // Synchronisers and edge-detect history
    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] copi_sync_q, copi_sync_d;
    logic [SYNC_STAGES-1:0] ncs_sync_q,  ncs_sync_d;
    logic                   sclk_hist_q, sclk_hist_d;
    logic                   ncs_hist_q,  ncs_hist_d;
    logic                   sclk_s, copi_s, ncs_s;
    logic                   sclk_rise, sclk_fall, ncs_rise, ncs_fall;

    // Frame engine state
    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
    logic [FRAME-1:0]       shift_q, shift_d;
    logic [DATA_W-1:0]      shadow_q, shadow_d;
    logic                   rw_q, rw_d;
    logic                   cipo_q, cipo_d;

    // Register bank and status
    logic [DATA_W-1:0]      regs_q [NUM_REGS];
    logic [DATA_W-1:0]      regs_d [NUM_REGS];
    logic                   wr_pulse_q, wr_pulse_d;
    logic [ADDR_W-1:0]      wr_addr_q, wr_addr_d;
    logic [7:0]             err_count_q, err_count_d;

    // Decoded views of the shift register
    logic [FRAME-1:0]       shift_in;
    logic                   frame_rw;
    logic [ADDR_W-1:0]      frame_addr;
    logic [DATA_W-1:0]      frame_data;
    logic                   frame_len_ok;
    logic                   frame_addr_ok;
    logic [DATA_W-1:0]      cmd_rd_value;

    // Shift the async pins through the synchroniser chains
    always_comb begin
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], spi.sclk};
        copi_sync_d = {copi_sync_q[SYNC_STAGES-2:0], spi.copi};
        ncs_sync_d  = {ncs_sync_q[SYNC_STAGES-2:0],  spi.ncs};
        sclk_hist_d = sclk_sync_q[SYNC_STAGES-1];
        ncs_hist_d  = ncs_sync_q[SYNC_STAGES-1];
    end

    // Synchroniser registers; idle bus levels on reset so no edge is seen
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync_q <= '0;
            copi_sync_q <= '0;
            ncs_sync_q  <= '1;
            sclk_hist_q <= 1'b0;
            ncs_hist_q  <= 1'b1;
        end else begin
            sclk_sync_q <= sclk_sync_d;
            copi_sync_q <= copi_sync_d;
            ncs_sync_q  <= ncs_sync_d;
            sclk_hist_q <= sclk_hist_d;
            ncs_hist_q  <= ncs_hist_d;
        end
    end

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign copi_s    = copi_sync_q[SYNC_STAGES-1];
    assign ncs_s     = ncs_sync_q[SYNC_STAGES-1];
    assign sclk_rise =  sclk_s & ~sclk_hist_q;
    assign sclk_fall = ~sclk_s &  sclk_hist_q;
    assign ncs_rise  =  ncs_s  & ~ncs_hist_q;
    assign ncs_fall  = ~ncs_s  &  ncs_hist_q;

    // Decode the collected frame and look up the readback value for the command just completing
    always_comb begin
        shift_in      = {shift_q[FRAME-2:0], copi_s};
        frame_rw      = shift_q[FRAME-1];
        frame_addr    = shift_q[DATA_W +: ADDR_W];
        frame_data    = shift_q[DATA_W-1:0];
        frame_len_ok  = (bit_cnt_q == CNT_W'(FRAME));
        frame_addr_ok = 1'b0;
        cmd_rd_value  = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (frame_addr == ADDR_W'(i)) begin
                frame_addr_ok = 1'b1;
            end
            if (shift_in[ADDR_W-1:0] == ADDR_W'(i)) begin
                cmd_rd_value = regs_q[i];
            end
        end
    end

    // Frame FSM: ncs edges take priority over sclk edges in the same clk
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        shadow_d    = shadow_q;
        rw_d        = rw_q;
        cipo_d      = cipo_q;
        regs_d      = regs_q;
        wr_pulse_d  = 1'b0;
        wr_addr_d   = wr_addr_q;
        err_count_d = err_count_q;

        if (ncs_rise) begin
            state_d = S_IDLE;
            cipo_d  = 1'b0;
            // A rise seen in IDLE has no fall behind it (e.g. after reset) and is ignored
            if (state_q != S_IDLE) begin
                if (frame_len_ok && frame_addr_ok) begin
                    if (frame_rw) begin
                        for (int i = 0; i < NUM_REGS; i++) begin
                            if (frame_addr == ADDR_W'(i)) begin
                                regs_d[i] = frame_data;
                            end
                        end
                        wr_addr_d  = frame_addr;
                        wr_pulse_d = 1'b1;
                    end
                end else if (err_count_q != 8'hFF) begin
                    err_count_d = err_count_q + 8'd1;
                end
            end
        end else if (ncs_fall) begin
            if (state_q == S_IDLE) begin
                state_d   = S_CMD;
                bit_cnt_d = '0;
                shift_d   = '0;
                shadow_d  = '0;
                rw_d      = 1'b0;
                cipo_d    = 1'b0;
            end
        end else if (sclk_rise) begin
            case (state_q)
                S_CMD: begin
                    shift_d   = shift_in;
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    if (bit_cnt_q == CNT_W'(CMD_BITS - 1)) begin
                        state_d  = S_DATA;
                        rw_d     = shift_in[CMD_BITS-1];
                        shadow_d = shift_in[CMD_BITS-1] ? '0 : cmd_rd_value;
                    end
                end
                S_DATA: begin
                    if (bit_cnt_q == CNT_W'(FRAME)) begin
                        // Overrun: the count moves past FRAME so the commit check rejects it
                        state_d   = S_DISCARD;
                        bit_cnt_d = CNT_W'(FRAME + 1);
                        cipo_d    = 1'b0;
                    end else begin
                        shift_d   = shift_in;
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end else if (sclk_fall) begin
            if (state_q == S_DATA && !rw_q) begin
                cipo_d   = shadow_q[DATA_W-1];
                shadow_d = {shadow_q[DATA_W-2:0], 1'b0};
            end
        end
    end

    // Frame engine, register bank and status registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            shadow_q    <= '0;
            rw_q        <= 1'b0;
            cipo_q      <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
            wr_pulse_q  <= 1'b0;
            wr_addr_q   <= '0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            shadow_q    <= shadow_d;
            rw_q        <= rw_d;
            cipo_q      <= cipo_d;
            regs_q      <= regs_d;
            wr_pulse_q  <= wr_pulse_d;
            wr_addr_q   <= wr_addr_d;
            err_count_q <= err_count_d;
        end
    end

    // Flatten the register bank for downstream config blocks
    always_comb begin
        regs_flat = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_flat[i*DATA_W +: DATA_W] = regs_q[i];
        end
    end

    assign spi.cipo    = cipo_q;
    assign spi.cipo_oe = ~ncs_s;
    assign wr_pulse    = wr_pulse_q;
    assign wr_addr     = wr_addr_q;
    assign err_count   = err_count_q;
endmodule

// File: tb/tb_spi_reg_bank_peripheral.sv
// tb/tb_spi_reg_bank_peripheral.sv - scoreboard bench for spi_reg_bank_peripheral
module tb_spi_reg_bank_peripheral;
    localparam int NUM_REGS = 5;
    localparam int DATA_W   = 8;
    localparam int ADDR_W   = 7;
    localparam int HALF     = 6;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    spi_reg_bank_peripheral_if spi_if ();
    logic [NUM_REGS*DATA_W-1:0] regs_flat;
    logic                       wr_pulse;
    logic [ADDR_W-1:0]          wr_addr;
    logic [7:0]                 err_count;

    spi_reg_bank_peripheral #(
        .NUM_REGS(NUM_REGS), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .SYNC_STAGES(2)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .spi(spi_if),
        .regs_flat(regs_flat),
        .wr_pulse(wr_pulse),
        .wr_addr(wr_addr),
        .err_count(err_count)
    );

    typedef struct {
        int         addr;
        logic [7:0] data;
    } wr_t;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] mdl_regs [NUM_REGS];
    int         mdl_err = 0;
    wr_t        exp_wr [$];
    logic [7:0] exp_rd [$];
    int         exp_err [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name);
        checks++;
        errors++;
        $display("FAIL %s actual=unexpected-event expected=none", name);
    endtask

    function automatic logic [NUM_REGS*DATA_W-1:0] mdl_flat();
        logic [NUM_REGS*DATA_W-1:0] f;
        f = '0;
        for (int i = 0; i < NUM_REGS; i++) f[i*DATA_W +: DATA_W] = mdl_regs[i];
        return f;
    endfunction

    // Reference: a frame is accepted only with exactly 16 bits and an address inside the bank
    task automatic model_frame(input bit rw, input int addr, input logic [7:0] data, input int nbits);
        bit len_ok;
        bit addr_ok;
        len_ok  = (nbits == 1 + ADDR_W + DATA_W);
        addr_ok = (addr < NUM_REGS);
        if (len_ok && !rw) exp_rd.push_back(addr_ok ? mdl_regs[addr] : 8'h00);
        if (len_ok && addr_ok) begin
            if (rw) begin
                mdl_regs[addr] = data;
                exp_wr.push_back('{addr, data});
            end
        end else if (mdl_err < 255) begin
            mdl_err++;
            exp_err.push_back(mdl_err);
        end
    endtask

    task automatic send_bits(input logic [15:0] f, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            spi_if.copi = (i < 16) ? f[15-i] : 1'($urandom_range(0, 1));
            repeat (HALF) @(negedge clk);
            spi_if.sclk = 1'b1;
            repeat (HALF) @(negedge clk);
            spi_if.sclk = 1'b0;
        end
    endtask

    task automatic spi_xfer(input bit rw, input int addr, input logic [7:0] data, input int nbits);
        logic [6:0]  a;
        logic [15:0] f;
        a = addr[6:0];
        f = {rw, a, data};
        model_frame(rw, addr, data, nbits);
        spi_if.ncs = 1'b0;
        repeat (HALF) @(negedge clk);
        send_bits(f, nbits);
        repeat (HALF) @(negedge clk);
        spi_if.ncs = 1'b1;
        repeat (12) @(negedge clk);
    endtask

    task automatic check_state(input string name);
        chk({name, ".regs_flat"}, 64'(regs_flat), 64'(mdl_flat()));
        chk({name, ".err_count"}, 64'(err_count), 64'(mdl_err));
    endtask

    // Write monitor: every wr_pulse must match the oldest expected write
    initial begin : wr_mon
        forever begin
            @(negedge clk);
            if (rst_n && wr_pulse) begin
                if (exp_wr.size() == 0) unexpected("wr_pulse");
                else begin
                    wr_t e;
                    e = exp_wr.pop_front();
                    chk("wr_addr", 64'(wr_addr), 64'(e.addr));
                    chk("wr_data", 64'(regs_flat[e.addr*DATA_W +: DATA_W]), 64'(e.data));
                end
            end
        end
    end

    // Error monitor: every change of err_count must match the next expected value
    initial begin : err_mon
        logic [7:0] last_err;
        last_err = 8'h00;
        forever begin
            @(negedge clk);
            if (!rst_n) last_err = 8'h00;
            else if (err_count != last_err) begin
                if (exp_err.size() == 0) unexpected("err_count_change");
                else chk("err_count_step", 64'(err_count), 64'(exp_err.pop_front()));
                last_err = err_count;
            end
        end
    end

    // Readback monitor: watches the pins like a controller, samples cipo on sclk rise
    initial begin : rd_mon
        int         bits;
        logic       rw;
        logic [7:0] rd;
        bits = 0;
        rw   = 1'b0;
        rd   = 8'h00;
        forever begin
            @(posedge spi_if.sclk or posedge spi_if.ncs);
            if (spi_if.ncs === 1'b1) begin
                if (bits == 16 && !rw) begin
                    if (exp_rd.size() == 0) unexpected("read_frame");
                    else chk("cipo_readback", 64'(rd), 64'(exp_rd.pop_front()));
                end
                bits = 0;
            end else begin
                if (bits == 0) rw = spi_if.copi;
                if (bits >= 8 && bits < 16) rd = {rd[6:0], spi_if.cipo};
                bits++;
            end
        end
    end

    initial begin : watchdog
        #2ms;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        for (int i = 0; i < NUM_REGS; i++) mdl_regs[i] = 8'h00;
        spi_if.sclk = 1'b0;
        spi_if.copi = 1'b0;
        spi_if.ncs  = 1'b1;
        repeat (5) @(negedge clk);
        chk("reset.regs_flat", 64'(regs_flat), 64'd0);
        chk("reset.err_count", 64'(err_count), 64'd0);
        chk("reset.wr_addr", 64'(wr_addr), 64'd0);
        chk("reset.wr_pulse", 64'(wr_pulse), 64'd0);
        chk("reset.cipo", 64'(spi_if.cipo), 64'd0);
        chk("reset.cipo_oe", 64'(spi_if.cipo_oe), 64'd0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        spi_xfer(1'b1, 3, 8'hA5, 16);
        check_state("t1");
        chk("t1.slot3", 64'(regs_flat[31:24]), 64'hA5);

        spi_xfer(1'b1, 1, 8'h3C, 16);
        spi_xfer(1'b0, 1, 8'($urandom), 16);
        check_state("t2");

        spi_xfer(1'b1, 5, 8'hFF, 16);
        chk("t3.err_after_write", 64'(err_count), 64'd1);
        spi_xfer(1'b0, 5, 8'h00, 16);
        check_state("t3");

        spi_xfer(1'b1, 2, 8'h55, 10);
        spi_xfer(1'b1, 2, 8'h66, 17);
        check_state("t4");

        // Reset mid-frame after 9 bits of a write to addr 0
        spi_if.ncs = 1'b0;
        repeat (HALF) @(negedge clk);
        send_bits({1'b1, 7'd0, 8'h77}, 9);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < NUM_REGS; i++) mdl_regs[i] = 8'h00;
        mdl_err = 0;
        chk("t5.regs_flat", 64'(regs_flat), 64'd0);
        chk("t5.err_count", 64'(err_count), 64'd0);
        chk("t5.wr_addr", 64'(wr_addr), 64'd0);
        chk("t5.wr_pulse", 64'(wr_pulse), 64'd0);
        chk("t5.cipo", 64'(spi_if.cipo), 64'd0);
        chk("t5.cipo_oe", 64'(spi_if.cipo_oe), 64'd0);
        repeat (3) @(negedge clk);
        spi_if.ncs = 1'b1;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check_state("t5.after");

        for (int n = 0; n < 60; n++) begin
            bit         rw;
            int         addr;
            int         nbits;
            logic [7:0] data;
            rw    = 1'($urandom_range(0, 1));
            addr  = ($urandom_range(0, 9) < 8) ? int'($urandom_range(0, NUM_REGS - 1))
                                              : int'($urandom_range(NUM_REGS, 127));
            data  = 8'($urandom);
            nbits = ($urandom_range(0, 9) < 7) ? 16 : int'($urandom_range(0, 20));
            spi_xfer(rw, addr, data, nbits);
        end
        check_state("random");

        repeat (256) spi_xfer(1'b0, 0, 8'h00, int'($urandom_range(0, 3)));
        chk("t6.saturated", 64'(err_count), 64'd255);
        spi_xfer(1'b1, 4, 8'($urandom), 16);
        check_state("t6");

        repeat (20) @(negedge clk);
        chk("drain.exp_wr", 64'(exp_wr.size()), 64'd0);
        chk("drain.exp_rd", 64'(exp_rd.size()), 64'd0);
        chk("drain.exp_err", 64'(exp_err.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
